// File: rtl/spike_rate_meter.sv
// Spike rate meter: counts rising edges of a neuron spike line over a fixed
// window, and measures the inter-spike interval between consecutive events.
module spike_rate_meter #(
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike_in,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic             rate_sat,
    output logic [15:0]      isi_out,
    output logic             isi_valid
);

    localparam int unsigned WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned ISI_W = 16;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ISI_W-1:0] ISI_MAX  = {ISI_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } isi_state_t;

    logic             spike_d;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] acc;
    logic             sat_flag;
    logic [ISI_W-1:0] isi_cnt;
    isi_state_t       state;
    isi_state_t       state_next;

    logic             event_c;
    logic             win_last_c;
    logic [CNT_W-1:0] acc_add_c;
    logic             sat_hit_c;
    logic             isi_load_c;
    logic [ISI_W-1:0] isi_cnt_next_c;

    // Rising edge of the spike line; a held-high spike is a single event.
    assign event_c    = spike_in & ~spike_d;
    assign win_last_c = (win_cnt == WIN_LAST);

    // Saturating add of this cycle's event into the window accumulator.
    always_comb begin
        acc_add_c = acc;
        sat_hit_c = 1'b0;
        if (event_c) begin
            if (acc == CNT_MAX) begin
                sat_hit_c = 1'b1;
            end else begin
                acc_add_c = acc + CNT_W'(1);
            end
        end
    end

    // Window counter, accumulator and rate outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_d    <= 1'b0;
            win_cnt    <= '0;
            acc        <= '0;
            sat_flag   <= 1'b0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            rate_sat   <= 1'b0;
        end else begin
            spike_d <= spike_in;
            if (win_last_c) begin
                // The closing cycle's own event belongs to the closing window.
                win_cnt    <= '0;
                rate_out   <= acc_add_c;
                rate_sat   <= sat_flag | sat_hit_c;
                rate_valid <= 1'b1;
                acc        <= '0;
                sat_flag   <= 1'b0;
            end else begin
                win_cnt    <= win_cnt + WIN_W'(1);
                rate_valid <= 1'b0;
                acc        <= acc_add_c;
                sat_flag   <= sat_flag | sat_hit_c;
            end
        end
    end

    // Interval counter restarts at 1 on each event and sticks at its maximum.
    always_comb begin
        if (event_c) begin
            isi_cnt_next_c = ISI_W'(1);
        end else if (isi_cnt == ISI_MAX) begin
            isi_cnt_next_c = isi_cnt;
        end else begin
            isi_cnt_next_c = isi_cnt + ISI_W'(1);
        end
    end

    // ISI tracker state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ISI tracker: the first event only arms the tracker, later events report.
    always_comb begin
        state_next = state;
        isi_load_c = 1'b0;
        case (state)
            IDLE: begin
                if (event_c) begin
                    state_next = TRACK;
                end
            end
            TRACK: begin
                isi_load_c = event_c;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ISI counter and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            isi_cnt   <= '0;
            isi_out   <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_cnt   <= isi_cnt_next_c;
            isi_valid <= isi_load_c;
            if (isi_load_c) begin
                isi_out <= isi_cnt;
            end
        end
    end

endmodule
